// File: rtl/fetch_pkg.sv
// Shared helpers for the instruction-fetch front end.
// The fetch entry layout depends on the top-level widths, so it is declared inside fetch_unit.
package fetch_pkg;

  // PC advance per fetched word, in bytes.
  function automatic int unsigned word_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush. Push on a full FIFO is accepted when a pop happens in the same cycle.
// The head word is read combinationally from registered storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage carries no reset; consumers gate the head word with empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential word requests with bounded outstanding count,
// in-order responses tagged with their PC and queued for decode; redirect flushes and discards.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter int                    BUF_DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INCR = ADDR_WIDTH'(word_bytes(DATA_WIDTH));

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [IW-1:0]         r_inflight;
  logic [IW-1:0]         r_discard;

  logic                  w_req_valid;
  logic                  w_req_fire;
  logic                  w_resp;
  logic                  w_resp_keep;
  logic                  w_out_pop;
  logic [31:0]           w_occupancy;
  logic [ADDR_WIDTH-1:0] w_pcq_pc;
  logic [IW-1:0]         w_pcq_count;
  logic                  w_pcq_full;
  logic                  w_pcq_empty;
  fetch_entry_t          w_buf_din;
  fetch_entry_t          w_buf_dout;
  logic [BW-1:0]         w_buf_count;
  logic                  w_buf_full;
  logic                  w_buf_empty;

  // Live in-flight words plus buffered words must fit the buffer, so responses never stall.
  assign w_occupancy = 32'(r_inflight) - 32'(r_discard) + 32'(w_buf_count);
  assign w_req_valid = rst && !redirect_valid
                    && (32'(r_inflight) < MAX_OUTSTANDING)
                    && (w_occupancy < BUF_DEPTH);
  assign w_req_fire  = w_req_valid && mem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign w_resp      = mem_resp_valid && (r_inflight != '0);
  assign w_resp_keep = w_resp && (r_discard == '0) && !redirect_valid;
  assign w_out_pop   = !w_buf_empty && out_ready && !redirect_valid;
  assign w_buf_din   = '{pc: w_pcq_pc, data: mem_resp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      if (redirect_valid)  r_pc <= redirect_pc;
      else if (w_req_fire) r_pc <= r_pc + PC_INCR;
      r_inflight <= r_inflight + IW'(w_req_fire) - IW'(w_resp);
      // Everything still in flight at a redirect is stale, except a response consumed this cycle.
      if (redirect_valid)
        r_discard <= r_inflight - IW'(w_resp);
      else if (w_resp && (r_discard != '0))
        r_discard <= r_discard - 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (IW)
  ) u_pc_queue (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_req_fire),
    .i_pop   (w_resp),
    .i_flush (1'b0),
    .i_din   (r_pc),
    .o_dout  (w_pcq_pc),
    .o_count (w_pcq_count),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH),
    .CW    (BW)
  ) u_fetch_buf (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_resp_keep),
    .i_pop   (w_out_pop),
    .i_flush (redirect_valid),
    .i_din   (w_buf_din),
    .o_dout  (w_buf_dout),
    .o_count (w_buf_count),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );

  assign mem_req_addr   = r_pc;
  assign mem_req_valid  = w_req_valid;
  assign mem_resp_ready = rst;
  assign out_valid      = !w_buf_empty;
  assign out_pc         = w_buf_empty ? '0 : w_buf_dout.pc;
  assign out_data       = w_buf_empty ? '0 : w_buf_dout.data;
  assign busy           = (r_inflight != '0);

  a_resp_inflight: assert property (@(posedge clk) disable iff (!rst)
    mem_resp_valid |-> (r_inflight != '0))
    else $error("fetch_unit: response with nothing in flight");

  a_pcq_track: assert property (@(posedge clk) disable iff (!rst)
    (w_pcq_count == r_inflight) && !(w_req_fire && w_pcq_full) && !(w_resp && w_pcq_empty))
    else $error("fetch_unit: PC queue out of step with in-flight count");

  a_buf_room: assert property (@(posedge clk) disable iff (!rst)
    w_resp_keep |-> (!w_buf_full || w_out_pop))
    else $error("fetch_unit: fetch buffer overflow");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable latency, output scoreboard,
// expected-entry table plus hand-written redirect and reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_ready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;

  fetch_unit #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4),
    .BUF_DEPTH       (4),
    .RESET_PC        (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_addr   (mem_req_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { int grp; int idx; logic [31:0] exp_pc; logic [31:0] exp_data; } vec_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  ent_t        got[$];
  vec_t        vt[8];
  int          cyc = 0;
  int          lat = 1;
  int          n_chk = 0;
  int          n_err = 0;

  // Memory: in-order, one response per cycle, word = address ^ KEY.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
    end else begin
      if (mem_resp_valid && mem_resp_ready && pend.size() > 0) pend.delete(0);
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{mem_req_addr, cyc + lat});
        req_log.push_back(mem_req_addr);
      end
      if (out_valid && out_ready) got.push_back('{out_pc, out_data});
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = pend[0].a ^ KEY;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] got_pc(input int i);
    return (i < got.size()) ? got[i].pc : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] got_data(input int i);
    return (i < got.size()) ? got[i].data : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] got_req(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_got(input int n, input int budget, input string nm);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(nm, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic check_grp(input int g);
    for (int i = 0; i < 8; i++) begin
      if (vt[i].grp == g) begin
        chk($sformatf("g%0d_pc%0d", g, vt[i].idx), got_pc(vt[i].idx), vt[i].exp_pc);
        chk($sformatf("g%0d_data%0d", g, vt[i].idx), got_data(vt[i].idx), vt[i].exp_data);
      end
    end
  endtask

  task automatic do_reset(input int l, input logic ordy);
    step();
    rst = 1'b0;
    mem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    req_log.delete();
    got.delete();
    lat = l;
    out_ready = ordy;
    mem_req_ready = 1'b1;
    rst = 1'b1;
  endtask

  initial begin
    int k;
    int bad;
    int n0;

    vt = '{
      '{1, 0, 32'h8000_0000, 32'h9234_5678},
      '{1, 1, 32'h8000_0004, 32'h9234_567C},
      '{1, 2, 32'h8000_0008, 32'h9234_5670},
      '{1, 3, 32'h8000_000C, 32'h9234_5674},
      '{4, 0, 32'h0000_0100, 32'h1234_5778},
      '{4, 1, 32'h0000_0104, 32'h1234_577C},
      '{5, 0, 32'h0000_0200, 32'h1234_5478},
      '{5, 1, 32'h0000_0204, 32'h1234_547C}
    };

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h8000_0000);
    chk("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Sequential fetch, 1-cycle memory
    step();
    lat = 1; out_ready = 1'b1; mem_req_ready = 1'b1; rst = 1'b1;
    wait_got(4, 40, "t1_wait");
    check_grp(1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_req%0d", i), got_req(i), 32'h8000_0000 + 32'(4 * i));

    // Decode stalled: buffer credit limits issue to 4
    do_reset(1, 1'b0);
    repeat (20) step();
    chk("t2_nreq", 32'(req_log.size()), 32'd4);
    chk("t2_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t2_head_pc", out_pc, 32'h8000_0000);
    chk("t2_head_data", out_data, 32'h9234_5678);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (6) step();
    chk("t2_nreq_after_pop", 32'(req_log.size()), 32'd5);
    chk("t2_req4", got_req(4), 32'h8000_0010);
    chk("t2_head_after_pop", out_pc, 32'h8000_0004);

    // Long latency: outstanding limit
    do_reset(10, 1'b1);
    k = 0; bad = 0;
    while (!mem_resp_valid && k < 40) begin
      step();
      k++;
      if (req_log.size() > 0 && !busy) bad++;
    end
    chk("t3_resp_seen", 32'(mem_resp_valid), 32'd1);
    chk("t3_accepted", 32'(req_log.size()), 32'd4);
    chk("t3_busy_drop", 32'(bad), 32'd0);
    wait_got(4, 60, "t3_wait");
    chk("t3_pc3", got_pc(3), 32'h8000_000C);

    // Redirect with 3 in flight
    do_reset(6, 1'b1);
    k = 0;
    while (req_log.size() < 3 && k < 20) begin step(); k++; end
    chk("t4_inflight", 32'(req_log.size()), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    chk("t4_no_req_on_redirect", 32'(mem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_resume_valid", 32'(mem_req_valid), 32'd1);
    chk("t4_resume_addr", mem_req_addr, 32'h0000_0100);
    wait_got(2, 80, "t4_wait");
    check_grp(4);

    // Redirect coinciding with a response and a stalled request, buffer non-empty
    do_reset(2, 1'b0);
    k = 0;
    while (!(mem_resp_valid && out_valid && mem_req_valid) && k < 20) begin step(); k++; end
    chk("t5_setup", 32'(mem_resp_valid && out_valid && mem_req_valid), 32'd1);
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("t5_withdrawn", 32'(mem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t5_flushed", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_resume_addr", mem_req_addr, 32'h0000_0200);
    n0 = req_log.size();
    wait_got(2, 60, "t5_wait");
    chk("t5_first_req", got_req(n0), 32'h0000_0200);
    check_grp(5);

    // Async reset mid-burst
    do_reset(10, 1'b1);
    k = 0;
    while (req_log.size() < 2 && k < 20) begin step(); k++; end
    mem_req_ready = 1'b0;
    step();
    chk("t6_busy_before", 32'(busy), 32'd1);
    chk("t6_addr_before", mem_req_addr, 32'h8000_0008);
    #1 rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t6_addr", mem_req_addr, 32'h8000_0000);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_resp_ready", 32'(mem_resp_ready), 32'd0);
    step();
    req_log.delete();
    got.delete();
    lat = 1; mem_req_ready = 1'b1; out_ready = 1'b1; rst = 1'b1;
    wait_got(1, 30, "t6_wait");
    chk("t6_restart_req", got_req(0), 32'h8000_0000);
    chk("t6_restart_pc", got_pc(0), 32'h8000_0000);
    chk("t6_restart_data", got_data(0), 32'h9234_5678);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end between the core and the memory port, replacing the idle request/response stub with a working engine. It keeps a fetch PC and issues sequential word requests on the valid/ready memory request channel, with up to MAX_OUTSTANDING requests in flight. In-order responses are tagged with their PC and queued in a fetch buffer that the decode stage drains. A redirect flushes the buffer and discards stale in-flight responses.

Parameters:
ADDR_WIDTH, 32, address/PC width
DATA_WIDTH, 32, fetch word width; power of two, at least 8
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests; at least 1
BUF_DEPTH, 4, fetch buffer entries; at least 1
RESET_PC, 32'h8000_0000, PC after reset (ADDR_WIDTH bits)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
mem_req_addr  out  ADDR_WIDTH  request address; equals the current fetch PC
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts the request
mem_resp_data  in  DATA_WIDTH  response word
mem_resp_valid  in  1  response valid
mem_resp_ready  out  1  response accept
redirect_valid  in  1  restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new PC
out_valid  out  1  fetch buffer non-empty
out_pc  out  ADDR_WIDTH  PC of the head entry
out_data  out  DATA_WIDTH  word of the head entry
out_ready  in  1  decode consumes the head entry
busy  out  1  in-flight count non-zero

Behaviour:
- Reset (rst low, async): pc=RESET_PC; inflight=0; discard=0; buffer and PC queue empty; all outputs 0; mem_req_addr=RESET_PC.
- Request credit: mem_req_valid = !redirect_valid && inflight<MAX_OUTSTANDING && (inflight-discard)+buf_count<BUF_DEPTH. The credit reserves buffer space, so mem_resp_ready is 1 whenever rst is high.
- Handshake: a request is accepted when mem_req_valid && mem_req_ready. On acceptance, push pc to the PC queue (depth MAX_OUTSTANDING), inflight+1, and pc <= pc + DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
- Protocol rule: mem_req_valid/addr hold stable until accepted. The one exception is the redirect cycle, where a pending unaccepted request is withdrawn.
- Response: on mem_resp_valid, pop the PC queue and decrement inflight. If discard>0, drop the word and decrement discard. Otherwise push {pc, data} into the buffer.
- Zero-bubble latency: a response in cycle N gives out_valid in cycle N+1 (registered buffer). Out_pop happens when out_valid && out_ready.
- Simultaneous push and pop on a full buffer is allowed. Simultaneous request acceptance and response: inflight is unchanged.
- Redirect (cycle N): buffer flushed, so out_valid=0 at N+1 (a same-cycle out_ready pop is moot). pc <= redirect_pc. discard <= inflight minus (1 if a non-discard or discard response arrives in cycle N). No request is issued in cycle N. Issue resumes at N+1 from redirect_pc. Back-to-back redirects: the last one wins, and discard recomputes each time.
- busy = inflight!=0.
- A response with inflight=0 is a protocol error; it is ignored, and a simulation assertion fires.
- Counter widths are $clog2(MAX_OUTSTANDING+1) and $clog2(BUF_DEPTH+1).

Decomposition:
- fetch_pkg: typedef fetch_entry_t {pc, data}, and a function for the word increment DATA_WIDTH/8.
- Sub-module sync_fifo (parametrised width/depth, push/pop/flush, count, full/empty). Instantiate it twice: as the PC queue and as the fetch buffer.
- fetch_unit holds the pc, inflight and discard counters, and the credit logic.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle memory -> requests 0x8000_0000, _0004, _0008, ... After 4 responses, out_pc sequence is 0x8000_0000..0x8000_000C with matching data.
- out_ready=0 and memory always ready -> exactly 4 requests issued (BUF_DEPTH). mem_req_valid stays 0 until one pop. After the pop, the next request is 0x8000_0010.
- Memory latency 10 cycles and MAX_OUTSTANDING=4 -> at most 4 accepted before the first response. busy=1 throughout.
- 3 in flight, then redirect_pc=0x100 -> buffer empties next cycle. The 3 stale responses are dropped. The first out_pc is 0x100, then 0x104.
- Redirect in the same cycle as a response and a stalled request -> the request is withdrawn, discard=inflight-1, and no stale entry reaches the output.
- rst asserted mid-burst with 2 in flight -> outputs return to reset values immediately. After release, fetch restarts at RESET_PC.
